operand_entry_seq: RTL and testbench

//  Front-end sequencer for the sum/difference datapath (Add_Sub_Top).

---
 rtl/sum_diff_pkg.sv | 13 +
 rtl/operand_entry_seq_debounce.sv | 46 ++++
 rtl/operand_entry_seq.sv | 102 ++++++++++
 tb/tb_operand_entry_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_diff_pkg.sv
// Shared types and constants for the sum/difference operand entry front end.
// The stage encoding is also consumed by the display logic for the stage LEDs.
package sum_diff_pkg;

    localparam int OPERAND_W = 6;

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        SHOW  = 2'd2
    } entry_state_t;

endpackage

// File: rtl/operand_entry_seq_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-count debounce and a
// one-cycle pulse on each debounced rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_press
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any sample that agrees with the accepted level restarts the count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/operand_entry_seq.sv
// Operand entry sequencer: captures A, then B plus op select, from shared
// switches on successive debounced presses and strobes the datapath.
module operand_entry_seq
    import sum_diff_pkg::*;
#(
    parameter int WIDTH           = OPERAND_W,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             add_sub_sw,
    input  logic             button_raw,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Add_Sub,
    output logic             button,
    output logic [1:0]       stage
);

    entry_state_t     r_state;
    entry_state_t     w_next_state;
    logic             w_press;
    logic             w_cap_a;
    logic             w_cap_b;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_add_sub;
    logic             r_button;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk   (clk),
        .i_reset (reset),
        .i_raw   (button_raw),
        .o_press (w_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = GET_A;
        w_cap_a      = 1'b0;
        w_cap_b      = 1'b0;
        case (r_state)
            GET_A: begin
                w_next_state = GET_A;
                if (w_press) begin
                    w_next_state = GET_B;
                    w_cap_a      = 1'b1;
                end
            end
            GET_B: begin
                w_next_state = GET_B;
                if (w_press) begin
                    w_next_state = SHOW;
                    w_cap_b      = 1'b1;
                end
            end
            SHOW: begin
                w_next_state = SHOW;
                if (w_press) begin
                    w_next_state = GET_A;
                end
            end
            // The unused encoding falls back to operand A entry.
            default: w_next_state = GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_add_sub <= 1'b0;
            r_button  <= 1'b0;
        end else begin
            r_button <= w_cap_b;
            if (w_cap_a) begin
                r_a <= sw;
            end
            if (w_cap_b) begin
                r_b       <= sw;
                r_add_sub <= add_sub_sw;
            end
        end
    end

    assign A       = r_a;
    assign B       = r_b;
    assign Add_Sub = r_add_sub;
    assign button  = r_button;
    assign stage   = r_state;

endmodule

// File: tb/tb_operand_entry_seq.sv
// Bench for operand_entry_seq with a short debounce window: table-driven operand
// sets, hand-written bounce/reset/hold sequences, and a strobe scoreboard.
module tb_operand_entry_seq;

    localparam int W  = 6;
    localparam int DC = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] sw;
    logic         add_sub_sw;
    logic         button_raw;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Add_Sub;
    logic         button;
    logic [1:0]   stage;

    int n_checks;
    int n_errors;

    // Scoreboard entries are {A, B, Add_Sub} expected on each strobe.
    logic [2*W:0] exp_q[$];
    logic [2*W:0] mon_exp;

    typedef struct {
        logic [W-1:0] a_sw;
        logic [W-1:0] b_sw;
        logic         op;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        logic         exp_op;
    } vec_t;

    vec_t vecs[4];

    operand_entry_seq #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .add_sub_sw (add_sub_sw),
        .button_raw (button_raw),
        .A          (A),
        .B          (B),
        .Add_Sub    (Add_Sub),
        .button     (button),
        .stage      (stage)
    );

    // clock / reset
    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic raw_pulse(input int hold);
        @(posedge clk);
        #1 button_raw = 1'b1;
        repeat (hold) @(posedge clk);
        #1 button_raw = 1'b0;
    endtask

    task automatic press();
        raw_pulse(6);
        idle(8);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && button) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: got A=%0d B=%0d op=%0d expected no strobe", A, B, Add_Sub);
            end else begin
                mon_exp = exp_q.pop_front();
                check("strobe_A", 32'(A), 32'(mon_exp[2*W:W+1]));
                check("strobe_B", 32'(B), 32'(mon_exp[W:1]));
                check("strobe_op", 32'(Add_Sub), 32'(mon_exp[0]));
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        sw         = '0;
        add_sub_sw = 1'b0;
        button_raw = 1'b0;
        reset      = 1'b1;

        vecs[0] = '{a_sw: 6'd0,  b_sw: 6'd63, op: 1'b1, exp_a: 6'd0,  exp_b: 6'd63, exp_op: 1'b1};
        vecs[1] = '{a_sw: 6'd63, b_sw: 6'd0,  op: 1'b0, exp_a: 6'd63, exp_b: 6'd0,  exp_op: 1'b0};
        vecs[2] = '{a_sw: 6'd42, b_sw: 6'd21, op: 1'b1, exp_a: 6'd42, exp_b: 6'd21, exp_op: 1'b1};
        vecs[3] = '{a_sw: 6'd1,  b_sw: 6'd1,  op: 1'b0, exp_a: 6'd1,  exp_b: 6'd1,  exp_op: 1'b0};

        // reset state
        idle(3);
        check("rst_A", 32'(A), 0);
        check("rst_B", 32'(B), 0);
        check("rst_op", 32'(Add_Sub), 0);
        check("rst_button", 32'(button), 0);
        check("rst_stage", 32'(stage), 0);
        reset = 1'b0;
        idle(2);

        // 1: basic A then B capture, strobe timing
        sw = 6'd15;
        press();
        check("t1_stage_b", 32'(stage), 1);
        check("t1_A", 32'(A), 15);
        sw         = 6'd8;
        add_sub_sw = 1'b0;
        exp_q.push_back({6'd15, 6'd8, 1'b0});
        @(posedge clk);
        #1 button_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t1_strobe_edge%0d", k), 32'(button), (k == 7) ? 1 : 0);
            if (k == 6) button_raw = 1'b0;
        end
        idle(8);
        check("t1_A_final", 32'(A), 15);
        check("t1_B_final", 32'(B), 8);
        check("t1_op_final", 32'(Add_Sub), 0);
        check("t1_stage_show", 32'(stage), 2);

        // 2: glitches shorter than the window are ignored
        raw_pulse(3);
        idle(8);
        check("t2_glitch_stage", 32'(stage), 2);
        raw_pulse(2);
        raw_pulse(3);
        idle(8);
        check("t2_bounce_stage", 32'(stage), 2);

        // 4: SHOW -> GET_A holds outputs without a strobe
        press();
        check("t4_stage_a", 32'(stage), 0);
        check("t4_A_hold", 32'(A), 15);
        check("t4_B_hold", 32'(B), 8);
        sw = 6'd14;
        press();
        check("t4_stage_b", 32'(stage), 1);

        // 3: switch sweep in GET_B has no effect
        for (int v = 0; v < 64; v++) begin
            sw = 6'(v);
            @(negedge clk);
            check("t3_A_hold", 32'(A), 14);
            check("t3_no_strobe", 32'(button), 0);
        end
        check("t3_stage", 32'(stage), 1);

        sw         = 6'd10;
        add_sub_sw = 1'b1;
        exp_q.push_back({6'd14, 6'd10, 1'b1});
        press();
        check("t4_A", 32'(A), 14);
        check("t4_B", 32'(B), 10);
        check("t4_op", 32'(Add_Sub), 1);
        check("t4_stage_show", 32'(stage), 2);

        // table-driven operand sets, each starting from SHOW
        for (int i = 0; i < 4; i++) begin
            press();
            check($sformatf("vec%0d_stage_a", i), 32'(stage), 0);
            sw         = vecs[i].a_sw;
            add_sub_sw = ~vecs[i].op;
            press();
            check($sformatf("vec%0d_stage_b", i), 32'(stage), 1);
            check($sformatf("vec%0d_A_mid", i), 32'(A), 32'(vecs[i].exp_a));
            sw         = vecs[i].b_sw;
            add_sub_sw = vecs[i].op;
            exp_q.push_back({vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_op});
            press();
            check($sformatf("vec%0d_A", i), 32'(A), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d_B", i), 32'(B), 32'(vecs[i].exp_b));
            check($sformatf("vec%0d_op", i), 32'(Add_Sub), 32'(vecs[i].exp_op));
            check($sformatf("vec%0d_stage", i), 32'(stage), 2);
        end

        // 5: reset during an in-flight debounce in GET_B
        press();
        sw = 6'd33;
        press();
        check("t5_stage_b", 32'(stage), 1);
        check("t5_A_pre", 32'(A), 33);
        @(posedge clk);
        #1 button_raw = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t5_A_rst", 32'(A), 0);
        check("t5_B_rst", 32'(B), 0);
        check("t5_op_rst", 32'(Add_Sub), 0);
        check("t5_button_rst", 32'(button), 0);
        check("t5_stage_rst", 32'(stage), 0);
        button_raw = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(12);
        check("t5_stage_after", 32'(stage), 0);
        check("t5_A_after", 32'(A), 0);

        // 6: long hold gives exactly one advance
        sw = 6'd5;
        raw_pulse(50);
        check("t6_stage_held", 32'(stage), 1);
        check("t6_A", 32'(A), 5);
        idle(8);
        check("t6_stage_release", 32'(stage), 1);
        sw         = 6'd7;
        add_sub_sw = 1'b0;
        exp_q.push_back({6'd5, 6'd7, 1'b0});
        press();
        check("t6_stage_next", 32'(stage), 2);
        check("t6_B", 32'(B), 7);

        // final report
        idle(4);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
